clk_gate_mc: RTL and testbench
==============================

CLK_GATE_MC -- requirements
Module: clk_gate_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently gated clock channels (1..32).
REQ-002 SHALL have parameter IDLE_W, default 4: width of the per-channel idle hysteresis counter.
REQ-003 SHALL have port clk_i, input, 1: the single source clock for all channels and logic.
REQ-004 SHALL have port arst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port en_req_i, input, NUM_CH: per-channel clock request.
REQ-006 SHALL have port busy_i, input, NUM_CH: per-channel activity flag; holds the clock on.
REQ-007 SHALL have port idle_thr_i, input, IDLE_W: idle cycles tolerated before gating; shared by all channels.
REQ-008 SHALL have port force_on_i, input, 1: test/scan override that opens all gates.
REQ-009 SHALL have port en_ack_o, output, NUM_CH: per-channel clock-running acknowledge.
REQ-010 SHALL have port gclk_o, output, NUM_CH: per-channel gated clock.

Function
REQ-011 SHALL run one FSM per channel with states OFF, WAKE, ON, DRAIN, all clocked on posedge clk_i.
REQ-012 SHALL move OFF->WAKE when en_req_i[c]=1, and stay in OFF otherwise.
REQ-013 SHALL always move WAKE->ON after exactly one cycle, regardless of inputs.
REQ-014 SHALL move ON->DRAIN, loading cnt[c]<=idle_thr_i, when en_req_i[c]=0 and busy_i[c]=0.
REQ-015 SHALL stay in ON while en_req_i[c] or busy_i[c] is 1.
REQ-016 SHALL move DRAIN->ON with no clock interruption when en_req_i[c] or busy_i[c] is 1 (request wins over expiry).
REQ-017 SHALL, in DRAIN with no request or busy: move to OFF if cnt[c]==0, else decrement cnt[c] by 1. Consequently idle_thr_i=0 gives one DRAIN cycle, and N gives N+1 DRAIN cycles.
REQ-018 SHALL sample idle_thr_i only on the ON->DRAIN transition; later changes SHALL NOT affect an active drain.
REQ-019 SHALL drive channel enable ch_en[c] = 1 in WAKE, ON and DRAIN, and 0 in OFF.
REQ-020 SHALL capture gate[c] = ch_en[c] | force_on_i on negedge clk_i, and drive gclk_o[c] = gate[c] & clk_i, so gclk_o has no glitches or truncated high phases.
REQ-021 SHALL drive en_ack_o[c] as a register that is 1 exactly in ON and DRAIN, and 0 in OFF and WAKE.
REQ-022 Latency: en_req_i sampled at posedge k produces the first gclk_o rising edge at posedge k+1 and en_ack_o high after posedge k+1.
REQ-023 SHALL leave the FSMs and en_ack_o unaffected by force_on_i; force_on_i only opens gates, taking effect from the next negedge.
REQ-024 SHALL keep channels fully independent; simultaneous events on several channels SHALL NOT interact.

Reset
REQ-025 SHALL, while arst_ni=0, immediately hold every FSM in OFF, cnt=0, ch_en=0, gate=0, en_ack_o=0 and gclk_o=0, independent of clk_i.
REQ-026 SHALL, on reset assertion mid-operation (including mid-high-phase of clk_i), force gclk_o low at once.
REQ-027 SHALL, after reset release, start all channels in OFF; the first gated edge follows the REQ-022 latency.

Structure
REQ-028 SHALL place the ch_state_e enum (OFF, WAKE, ON, DRAIN) and the default NUM_CH/IDLE_W constants in shared package clk_gate_pkg.
REQ-029 SHALL implement the per-channel negedge gate register and AND in sub-module clk_gate_cell (ports: clk_i, arst_ni, en_i, gclk_o), instantiated NUM_CH times.

Verification
REQ-030 Wake/sleep: idle_thr_i=3, pulse en_req_i[0] high for 5 cycles -> ack rises 2 edges after request; gclk_o[0] toggles for 5+4 cycles after WAKE, then stays low; ack falls together with OFF.
REQ-031 Re-request in drain: idle_thr_i=5, drop en_req_i[1], re-raise it on drain cycle 2 -> FSM returns to ON, gclk_o[1] has no missing pulse, ack stays 1.
REQ-032 Busy hold: en_req_i[2]=0 with busy_i[2]=1 for 10 cycles while in ON -> stays ON; drain starts on the cycle busy drops.
REQ-033 Zero threshold: idle_thr_i=0, drop request -> exactly one DRAIN cycle, then OFF; gclk_o gated from the following negedge.
REQ-034 Force: all requests 0, force_on_i=1 -> all gclk_o follow clk_i from the next negedge with full high phases; en_ack_o stays 0.
REQ-035 Async reset: assert arst_ni low mid-high-phase with all channels ON -> gclk_o and en_ack_o go 0 immediately; after release, FSMs are in OFF.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// -----------------------------------------------------------------------------
// clk_gate_pkg
// Shared definitions for the multi-channel clock gate:
//   - ch_state_e   : per-channel gating FSM state
//   - DEF_NUM_CH   : default number of gated channels
//   - DEF_IDLE_W   : default width of the idle hysteresis counter
// -----------------------------------------------------------------------------
package clk_gate_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,  // gate closed, waiting for a request
      WAKE  = 2'd1,  // gate opening, first gated edge on the next posedge
      ON    = 2'd2,  // clock running, acknowledged
      DRAIN = 2'd3   // clock still running while the idle counter expires
   } ch_state_e;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_IDLE_W = 4;

endpackage : clk_gate_pkg

// File: rtl/clk_gate_cell.sv
// -----------------------------------------------------------------------------
// clk_gate_cell
// Glitch-free clock gate for one channel. The enable is captured while the
// source clock is low, so the AND output can only open or close between
// high phases and never produces a truncated pulse.
//   clk_i   : source clock
//   arst_ni : asynchronous active-low reset, closes the gate immediately
//   en_i    : gate enable (may change anywhere in the cycle)
//   gclk_o  : gated clock
// -----------------------------------------------------------------------------
module clk_gate_cell (
   input  logic clk_i,
   input  logic arst_ni,
   input  logic en_i,
   output logic gclk_o
);

   logic gate_d;
   logic gate_q;

   always_comb begin
      gate_d = en_i;
   end

   // Negedge capture: gate_q is stable for the whole high phase of clk_i.
   always_ff @(negedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         gate_q <= 1'b0;
      end else begin
         gate_q <= gate_d;
      end
   end

   assign gclk_o = gate_q & clk_i;

endmodule : clk_gate_cell

// File: rtl/clk_gate_mc.sv
// -----------------------------------------------------------------------------
// clk_gate_mc
// Multi-channel clock gate with request/acknowledge handshake and idle
// hysteresis. Each channel runs an independent OFF/WAKE/ON/DRAIN FSM; the
// channel enable drives a negedge-captured gate cell.
//   clk_i      : source clock for all channels
//   arst_ni    : asynchronous active-low reset
//   en_req_i   : per-channel clock request
//   busy_i     : per-channel activity flag, keeps the clock running
//   idle_thr_i : idle cycles tolerated before gating (sampled on ON->DRAIN)
//   force_on_i : test/scan override, opens every gate, FSMs unaffected
//   en_ack_o   : per-channel acknowledge, high in ON and DRAIN
//   gclk_o     : per-channel gated clock
// -----------------------------------------------------------------------------
module clk_gate_mc
   import clk_gate_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int IDLE_W = DEF_IDLE_W
) (
   input  logic              clk_i,
   input  logic              arst_ni,
   input  logic [NUM_CH-1:0] en_req_i,
   input  logic [NUM_CH-1:0] busy_i,
   input  logic [IDLE_W-1:0] idle_thr_i,
   input  logic              force_on_i,
   output logic [NUM_CH-1:0] en_ack_o,
   output logic [NUM_CH-1:0] gclk_o
);

   ch_state_e         state_d [NUM_CH];
   ch_state_e         state_q [NUM_CH];
   logic [IDLE_W-1:0] cnt_d   [NUM_CH];
   logic [IDLE_W-1:0] cnt_q   [NUM_CH];
   logic [NUM_CH-1:0] ack_d;
   logic [NUM_CH-1:0] ack_q;
   logic [NUM_CH-1:0] ch_en;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         // NOTE: every combinational output gets a default first so no path
         // leaves it unassigned, which would otherwise infer a latch.
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];

         unique case (state_q[c])
            OFF: begin
               if (en_req_i[c]) state_d[c] = WAKE;
            end
            WAKE: begin
               state_d[c] = ON;
            end
            ON: begin
               if (!(en_req_i[c] || busy_i[c])) begin
                  state_d[c] = DRAIN;
                  cnt_d[c]   = idle_thr_i;
               end
            end
            DRAIN: begin
               // A request or busy flag wins over counter expiry.
               if (en_req_i[c] || busy_i[c]) begin
                  state_d[c] = ON;
               end else if (cnt_q[c] == '0) begin
                  state_d[c] = OFF;
               end else begin
                  cnt_d[c] = cnt_q[c] - IDLE_W'(1);
               end
            end
            default: state_d[c] = OFF;
         endcase

         // Registered acknowledge follows the next state.
         ack_d[c] = (state_d[c] == ON) || (state_d[c] == DRAIN);
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= OFF;
            cnt_q[c]   <= '0;
         end
         ack_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
         end
         ack_q <= ack_d;
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_en[c] = (state_q[c] != OFF);
      end
   end

   assign en_ack_o = ack_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_cell
      clk_gate_cell u_cell (
         .clk_i   (clk_i),
         .arst_ni (arst_ni),
         .en_i    (ch_en[c] | force_on_i),
         .gclk_o  (gclk_o[c])
      );
   end

endmodule : clk_gate_mc

// File: tb/tb_clk_gate_mc.sv
// -----------------------------------------------------------------------------
// tb_clk_gate_mc
// Directed bench for clk_gate_mc. After each posedge plus 1 ns the clock is
// high, so gclk_o shows whether that edge was passed through and en_ack_o
// shows the state registered on that edge.
// -----------------------------------------------------------------------------
module tb_clk_gate_mc;

   localparam int NUM_CH = 4;
   localparam int IDLE_W = 4;

   logic              clk_i;
   logic              arst_ni;
   logic [NUM_CH-1:0] en_req_i;
   logic [NUM_CH-1:0] busy_i;
   logic [IDLE_W-1:0] idle_thr_i;
   logic              force_on_i;
   logic [NUM_CH-1:0] en_ack_o;
   logic [NUM_CH-1:0] gclk_o;

   int total;
   int bad;

   clk_gate_mc #(
      .NUM_CH (NUM_CH),
      .IDLE_W (IDLE_W)
   ) dut (
      .clk_i      (clk_i),
      .arst_ni    (arst_ni),
      .en_req_i   (en_req_i),
      .busy_i     (busy_i),
      .idle_thr_i (idle_thr_i),
      .force_on_i (force_on_i),
      .en_ack_o   (en_ack_o),
      .gclk_o     (gclk_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      arst_ni    = 1'b0;
      en_req_i   = '0;
      busy_i     = '0;
      idle_thr_i = '0;
      force_on_i = 1'b0;

      // Reset state, sampled during a high phase.
      step();
      check("rst_gclk", 32'(gclk_o), 32'h0);
      check("rst_ack", 32'(en_ack_o), 32'h0);
      step();
      arst_ni = 1'b1;
      step();
      check("post_rst_gclk", 32'(gclk_o), 32'h0);
      check("post_rst_ack", 32'(en_ack_o), 32'h0);

      // Wake/sleep on ch0, thr=3, request held for 5 sampled edges.
      // Threshold change mid-drain must be ignored.
      idle_thr_i = 4'd3;
      en_req_i   = 4'b0001;
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("ws_ack_%0d", k), 32'(en_ack_o),
               (k >= 2 && k <= 9) ? 32'h1 : 32'h0);
         check($sformatf("ws_gclk_%0d", k), 32'(gclk_o),
               (k >= 2 && k <= 10) ? 32'h1 : 32'h0);
         if (k == 5) en_req_i = 4'b0000;
         if (k == 7) idle_thr_i = 4'd15;
      end

      // Re-request in drain on ch1, thr=5.
      idle_thr_i = 4'd5;
      en_req_i   = 4'b0010;
      for (int k = 1; k <= 14; k++) begin
         step();
         check($sformatf("rd_ack_%0d", k), 32'(en_ack_o),
               (k >= 2 && k <= 12) ? 32'h2 : 32'h0);
         check($sformatf("rd_gclk_%0d", k), 32'(gclk_o),
               (k >= 2 && k <= 13) ? 32'h2 : 32'h0);
         if (k == 2) en_req_i = 4'b0000;
         if (k == 4) en_req_i = 4'b0010;
         if (k == 6) en_req_i = 4'b0000;
      end

      // Busy hold on ch2, thr=2: busy alone holds ON for 10 edges.
      idle_thr_i = 4'd2;
      en_req_i   = 4'b0100;
      for (int k = 1; k <= 17; k++) begin
         step();
         check($sformatf("bh_ack_%0d", k), 32'(en_ack_o),
               (k >= 2 && k <= 15) ? 32'h4 : 32'h0);
         check($sformatf("bh_gclk_%0d", k), 32'(gclk_o),
               (k >= 2 && k <= 16) ? 32'h4 : 32'h0);
         if (k == 2) begin
            en_req_i = 4'b0000;
            busy_i   = 4'b0100;
         end
         if (k == 12) busy_i = 4'b0000;
      end

      // Zero threshold on ch3: exactly one DRAIN cycle.
      idle_thr_i = 4'd0;
      en_req_i   = 4'b1000;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("zt_ack_%0d", k), 32'(en_ack_o),
               (k >= 2 && k <= 3) ? 32'h8 : 32'h0);
         check($sformatf("zt_gclk_%0d", k), 32'(gclk_o),
               (k >= 2 && k <= 4) ? 32'h8 : 32'h0);
         if (k == 2) en_req_i = 4'b0000;
      end

      // Force override: takes effect from the next negedge, full high phases.
      step();
      force_on_i = 1'b1;
      #1;
      check("frc_same_phase", 32'(gclk_o), 32'h0);
      step();
      check("frc_gclk_on", 32'(gclk_o), 32'hF);
      check("frc_ack", 32'(en_ack_o), 32'h0);
      #3;
      check("frc_full_high", 32'(gclk_o), 32'hF);
      step();
      force_on_i = 1'b0;
      #1;
      check("frc_drop_no_trunc", 32'(gclk_o), 32'hF);
      step();
      check("frc_gclk_off", 32'(gclk_o), 32'h0);
      check("frc_ack_off", 32'(en_ack_o), 32'h0);

      // Asynchronous reset mid-high-phase with all channels ON.
      en_req_i = 4'b1111;
      step();
      step();
      check("ar_ack_on", 32'(en_ack_o), 32'hF);
      check("ar_gclk_on", 32'(gclk_o), 32'hF);
      #1;
      arst_ni = 1'b0;
      #1;
      check("ar_gclk_now", 32'(gclk_o), 32'h0);
      check("ar_ack_now", 32'(en_ack_o), 32'h0);
      en_req_i = 4'b0000;
      step();
      check("ar_held_gclk", 32'(gclk_o), 32'h0);
      step();
      arst_ni = 1'b1;
      step();
      check("ar_rel_ack", 32'(en_ack_o), 32'h0);
      check("ar_rel_gclk", 32'(gclk_o), 32'h0);

      // First gated edge after release follows the normal latency.
      en_req_i = 4'b0001;
      step();
      check("ar_lat_gclk_wake", 32'(gclk_o), 32'h0);
      check("ar_lat_ack_wake", 32'(en_ack_o), 32'h0);
      step();
      check("ar_lat_gclk_on", 32'(gclk_o), 32'h1);
      check("ar_lat_ack_on", 32'(en_ack_o), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_clk_gate_mc
